mem_wb_writeback: RTL and testbench
===================================

Name: mem_wb_writeback

Overview:
- Downstream neighbour of the memory stage.
- Latches the 20-bit memory-stage result bundle into the MEM/WB pipeline register and commits it to an 8x16 register file one cycle later.
- Provides two combinational register-file read ports with write-through bypass for the decode stage.
- Exposes the committed write (valid/dest/data) as the forwarding source for execute.
- Counts committed write-backs.

Parameters:
- DATA_W, 16, data path width; must equal the memory-stage data field width.
- ADDR_W, 3, register address width.
- NREGS, 8, register count; must equal 2**ADDR_W.
- CNT_W, 16, width of the write-back commit counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-low (0 = reset, sampled on the clk rising edge).
- mem_in  input  20  memory-stage bundle: [15:0] result data, [18:16] destination register, [19] write-back enable.
- stall  input  1  hold the MEM/WB register contents.
- flush  input  1  insert a bubble into the MEM/WB register.
- rd_addr1  input  ADDR_W  read port 1 address.
- rd_addr2  input  ADDR_W  read port 2 address.
- rd_data1  output  DATA_W  read port 1 data (combinational).
- rd_data2  output  DATA_W  read port 2 data (combinational).
- wb_valid  output  1  registered write-back enable; forwarding source.
- wb_dest  output  ADDR_W  registered destination register.
- wb_data  output  DATA_W  registered write-back data.
- wb_count  output  CNT_W  number of committed register-file writes.

Behaviour:
- Reset (rst==0 at a clk edge): wb_valid=0, wb_dest=0, wb_data=0, wb_count=0, all NREGS registers=0. Reset overrides flush, stall, and any pending commit; an in-flight write is dropped.
- MEM/WB register update, priority flush > stall > load:
  - flush: wb_valid<=0, wb_dest<=0, wb_data<=0.
  - stall (no flush): all three fields hold.
  - otherwise: wb_valid<=mem_in[19], wb_dest<=mem_in[18:16], wb_data<=mem_in[15:0].
- Commit: at every non-reset clk edge where wb_valid==1, regs[wb_dest]<=wb_data and wb_count<=wb_count+1. wb_count wraps from 2**CNT_W-1 to 0.
  - Commit uses the pre-edge register values, so it proceeds regardless of stall or flush on that edge.
  - During a stall with wb_valid==1 the same write recommits each cycle (idempotent data). wb_count increments each of those cycles, so it counts commit cycles, not instructions.
- Latency: mem_in sampled at edge N appears on wb_* after edge N. The register file holds the value after edge N+1.
- Reads are combinational. Bypass rule: if wb_valid==1 and rd_addrX==wb_dest, rd_dataX=wb_data; otherwise rd_dataX=regs[rd_addrX]. Both ports bypass independently, and equal addresses return identical data.
- Register 0 is an ordinary writable register (no hardwired zero).
- X-safety: a bubble (wb_valid==0) never writes and never bypasses, whatever wb_dest/wb_data contain.
- No handshake toward the memory stage. stall and flush are owned by the hazard unit. flush and stall asserted together produce a bubble.

Test Plan:
- Reset: hold rst=0 for 2 cycles with mem_in=20'hFFFFF → wb_valid=0, wb_count=0, and rd_data1/rd_data2=0 for every address after release.
- Basic commit: mem_in={1'b1,3'd5,16'hBEEF} for one cycle, then mem_in=0 → wb_valid=1, wb_dest=5, wb_data=BEEF after edge 1. regs[5]=BEEF after edge 2 and wb_count=1. rd_addr1=5 reads BEEF from edge 1 onward via bypass, then from storage.
- Back-to-back same destination: writes {1,3'd2,16'h0001} then {1,3'd2,16'h0002} → rd_addr2=2 returns 0001, then 0002, with no stale cycle. Final regs[2]=0002, wb_count=2.
- Stall/flush: load {1,3'd3,16'h1234}, stall for 3 cycles with differing mem_in → wb_* held and wb_count increments by 4 in total. Then flush+stall together → wb_valid=0, the next edge performs no write, and regs[3]=1234.
- Non-write bubble: mem_in={1'b0,3'd4,16'hDEAD} → wb_valid=0, regs[4] unchanged, rd_addr1=4 does not return DEAD, and wb_count unchanged.
- Reset mid-operation and counter wrap: drive rst=0 on the edge where wb_valid=1 for {1,3'd6,16'hAAAA} → regs[6]=0 and wb_count=0. With CNT_W=4, perform 17 commits → wb_count=1.

Source files
------------

// File: rtl/mem_wb_writeback.sv
// mem_wb_writeback: MEM/WB pipeline register, register file commit,
// bypassed decode read ports and committed write-back counter.
module mem_wb_writeback #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3,
  parameter int NREGS  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W+ADDR_W:0]   mem_in,
  input  logic                     stall,
  input  logic                     flush,
  input  logic [ADDR_W-1:0]        rd_addr1,
  input  logic [ADDR_W-1:0]        rd_addr2,
  output logic [DATA_W-1:0]        rd_data1,
  output logic [DATA_W-1:0]        rd_data2,
  output logic                     wb_valid,
  output logic [ADDR_W-1:0]        wb_dest,
  output logic [DATA_W-1:0]        wb_data,
  output logic [CNT_W-1:0]         wb_count
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } mem_wb_t;

  mem_wb_t             in_b;
  mem_wb_t             wb_q;
  logic [DATA_W-1:0]   regs [NREGS];
  logic [CNT_W-1:0]    cnt_q;

  assign in_b = mem_in;

  // Flush beats stall so a combined request still yields a bubble.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_q <= '0;
    end else if (flush) begin
      wb_q <= '0;
    end else if (!stall) begin
      wb_q <= in_b;
    end
  end

  // Commit follows the pre-edge MEM/WB contents, independent of stall/flush.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_q.valid) begin
      regs[wb_q.dest] <= wb_q.data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (wb_q.valid) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A bubble never bypasses, whatever stale dest/data it carries.
  always_comb begin
    rd_data1 = regs[rd_addr1];
    if (wb_q.valid && (rd_addr1 == wb_q.dest)) begin
      rd_data1 = wb_q.data;
    end
  end

  always_comb begin
    rd_data2 = regs[rd_addr2];
    if (wb_q.valid && (rd_addr2 == wb_q.dest)) begin
      rd_data2 = wb_q.data;
    end
  end

  assign wb_valid = wb_q.valid;
  assign wb_dest  = wb_q.dest;
  assign wb_data  = wb_q.data;
  assign wb_count = cnt_q;

endmodule

// File: tb/tb_mem_wb_writeback.sv
// tb_mem_wb_writeback: directed checks of the MEM/WB write-back stage,
// with a narrow-counter instance for wrap behaviour.
module tb_mem_wb_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic [19:0] mem_in;
  logic        stall;
  logic        flush;
  logic [2:0]  rd_addr1;
  logic [2:0]  rd_addr2;
  logic [15:0] rd_data1;
  logic [15:0] rd_data2;
  logic        wb_valid;
  logic [2:0]  wb_dest;
  logic [15:0] wb_data;
  logic [15:0] wb_count;

  logic [15:0] n_rd_data1;
  logic [15:0] n_rd_data2;
  logic        n_wb_valid;
  logic [2:0]  n_wb_dest;
  logic [15:0] n_wb_data;
  logic [3:0]  n_wb_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_wb_writeback dut (
    .clk(clk), .rst(rst), .mem_in(mem_in),
    .stall(stall), .flush(flush),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(rd_data1), .rd_data2(rd_data2),
    .wb_valid(wb_valid), .wb_dest(wb_dest),
    .wb_data(wb_data), .wb_count(wb_count)
  );

  mem_wb_writeback #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .mem_in(mem_in),
    .stall(stall), .flush(flush),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .rd_data1(n_rd_data1), .rd_data2(n_rd_data2),
    .wb_valid(n_wb_valid), .wb_dest(n_wb_dest),
    .wb_data(n_wb_data), .wb_count(n_wb_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_in = 20'hFFFFF;
    stall = 1'b0; flush = 1'b0;
    rd_addr1 = 3'd0; rd_addr2 = 3'd0;
    tick(); tick();
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got %b exp 0", wb_valid);
    end
    checks++;
    if (wb_count !== 16'd0) begin
      errors++; $display("FAIL reset_count got %0d exp 0", wb_count);
    end
    rst = 1'b1; mem_in = 20'h0;
    for (int a = 0; a < 8; a++) begin
      rd_addr1 = 3'(a); rd_addr2 = 3'(7 - a);
      #1;
      checks++;
      if (rd_data1 !== 16'h0 || rd_data2 !== 16'h0) begin
        errors++;
        $display("FAIL reset_read a=%0d got %h/%h exp 0000",
                 a, rd_data1, rd_data2);
      end
    end
  endtask

  task automatic test_basic();
    rd_addr1 = 3'd5; rd_addr2 = 3'd5;
    mem_in = {1'b1, 3'd5, 16'hBEEF};
    tick();
    checks++;
    if (wb_valid !== 1'b1 || wb_dest !== 3'd5 || wb_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL basic_wb got %b/%0d/%h exp 1/5/beef",
               wb_valid, wb_dest, wb_data);
    end
    checks++;
    if (rd_data1 !== 16'hBEEF) begin
      errors++; $display("FAIL basic_bypass got %h exp beef", rd_data1);
    end
    checks++;
    if (wb_count !== 16'd0) begin
      errors++; $display("FAIL basic_count0 got %0d exp 0", wb_count);
    end
    mem_in = 20'h0;
    tick();
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++; $display("FAIL basic_idle got %b exp 0", wb_valid);
    end
    checks++;
    if (rd_data1 !== 16'hBEEF || rd_data2 !== 16'hBEEF) begin
      errors++;
      $display("FAIL basic_store got %h/%h exp beef", rd_data1, rd_data2);
    end
    checks++;
    if (wb_count !== 16'd1) begin
      errors++; $display("FAIL basic_count got %0d exp 1", wb_count);
    end
  endtask

  task automatic test_back_to_back();
    rd_addr1 = 3'd2; rd_addr2 = 3'd2;
    mem_in = {1'b1, 3'd2, 16'h0001};
    tick();
    checks++;
    if (rd_data2 !== 16'h0001 || rd_data1 !== rd_data2) begin
      errors++;
      $display("FAIL b2b_first got %h/%h exp 0001", rd_data1, rd_data2);
    end
    mem_in = {1'b1, 3'd2, 16'h0002};
    tick();
    checks++;
    if (rd_data2 !== 16'h0002) begin
      errors++; $display("FAIL b2b_second got %h exp 0002", rd_data2);
    end
    mem_in = 20'h0;
    tick();
    checks++;
    if (rd_data2 !== 16'h0002) begin
      errors++; $display("FAIL b2b_store got %h exp 0002", rd_data2);
    end
    checks++;
    if (wb_count !== 16'd3) begin
      errors++; $display("FAIL b2b_count got %0d exp 3", wb_count);
    end
  endtask

  task automatic test_stall_flush();
    rd_addr1 = 3'd3; rd_addr2 = 3'd0;
    mem_in = {1'b1, 3'd3, 16'h1234};
    tick();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      mem_in = {1'b1, 3'(k), 16'hC000 + 16'(k)};
      tick();
      checks++;
      if (wb_valid !== 1'b1 || wb_dest !== 3'd3 || wb_data !== 16'h1234) begin
        errors++;
        $display("FAIL stall_hold k=%0d got %b/%0d/%h exp 1/3/1234",
                 k, wb_valid, wb_dest, wb_data);
      end
    end
    checks++;
    if (wb_count !== 16'd6) begin
      errors++; $display("FAIL stall_count got %0d exp 6", wb_count);
    end
    flush = 1'b1;
    tick();
    checks++;
    if (wb_valid !== 1'b0 || wb_count !== 16'd7) begin
      errors++;
      $display("FAIL flush_stall got %b/%0d exp 0/7", wb_valid, wb_count);
    end
    stall = 1'b0; flush = 1'b0; mem_in = 20'h0;
    tick();
    checks++;
    if (wb_count !== 16'd7 || rd_data1 !== 16'h1234) begin
      errors++;
      $display("FAIL flush_after got %0d/%h exp 7/1234", wb_count, rd_data1);
    end
    checks++;
    if (rd_data2 !== 16'h0000) begin
      errors++; $display("FAIL stall_r0 got %h exp 0000", rd_data2);
    end
  endtask

  task automatic test_bubble();
    rd_addr1 = 3'd4; rd_addr2 = 3'd4;
    mem_in = {1'b0, 3'd4, 16'hDEAD};
    tick();
    checks++;
    if (wb_valid !== 1'b0) begin
      errors++; $display("FAIL bubble_valid got %b exp 0", wb_valid);
    end
    checks++;
    if (rd_data1 !== 16'h0000) begin
      errors++; $display("FAIL bubble_bypass got %h exp 0000", rd_data1);
    end
    mem_in = 20'h0;
    tick();
    checks++;
    if (rd_data2 !== 16'h0000 || wb_count !== 16'd7) begin
      errors++;
      $display("FAIL bubble_store got %h/%0d exp 0000/7", rd_data2, wb_count);
    end
  endtask

  task automatic test_reset_mid();
    rd_addr1 = 3'd6; rd_addr2 = 3'd6;
    mem_in = {1'b1, 3'd6, 16'hAAAA};
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1; mem_in = 20'h0;
    #1;
    checks++;
    if (rd_data1 !== 16'h0000 || wb_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_reg got %h/%b exp 0000/0", rd_data1, wb_valid);
    end
    checks++;
    if (wb_count !== 16'd0 || n_wb_count !== 4'd0) begin
      errors++;
      $display("FAIL midrst_count got %0d/%0d exp 0/0", wb_count, n_wb_count);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 17; i++) begin
      mem_in = {1'b1, 3'(i), 16'(i)};
      tick();
    end
    mem_in = 20'h0;
    tick();
    checks++;
    if (n_wb_count !== 4'd1) begin
      errors++; $display("FAIL wrap_narrow got %0d exp 1", n_wb_count);
    end
    checks++;
    if (wb_count !== 16'd17) begin
      errors++; $display("FAIL wrap_wide got %0d exp 17", wb_count);
    end
    rd_addr1 = 3'd0; rd_addr2 = 3'd7;
    #1;
    checks++;
    if (rd_data1 !== 16'h0010 || rd_data2 !== 16'h000F) begin
      errors++;
      $display("FAIL wrap_regs got %h/%h exp 0010/000f", rd_data1, rd_data2);
    end
  endtask

  initial begin
    test_reset();
    tick();
    test_basic();
    test_back_to_back();
    test_stall_flush();
    test_bubble();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
